// File: rtl/seg7_scan_mux_if.sv
// Word-in handshake bundle for the seven-segment scan driver.
// Latency: n/a (wires only).
// Backpressure: in_ready low while the driver's pending buffer is occupied.
interface seg7_scan_mux_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic [3:0]  in_dp;

  modport master (output in_valid, output in_bcd, output in_dp, input in_ready);
  modport slave  (input in_valid, input in_bcd, input in_dp, output in_ready);
endinterface

// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed 7-segment driver: one-hot scan, blanking gap, 16-step PWM, tear-free word update.
// Latency: an accepted word is shown from the frame after the next frame boundary; all outputs registered.
// Backpressure: in_ready drops while a word waits in the pending buffer and rises the cycle after a frame boundary.
module seg7_scan_mux #(
  parameter int SCAN_DIV     = 2500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_scan_mux_if.slave        in_if,
  input  logic                  blank_lz_i,
  input  logic [3:0]            brightness_i,
  output logic [6:0]            seg_out_o,
  output logic                  dp_out_o,
  output logic [3:0]            dig_sel_o,
  output logic                  frame_done_o,
  output logic                  err_bcd_o
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] ON_LAST    = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {PH_BLANK, PH_ON} phase_e;

  phase_e          phase_q, phase_d;
  logic [1:0]      dig_q, dig_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      pwm_q, pwm_d;
  logic            pend_full_q, pend_full_d;
  logic [15:0]     pend_bcd_q, pend_bcd_d;
  logic [3:0]      pend_dp_q, pend_dp_d;
  logic [15:0]     shad_bcd_q, shad_bcd_d;
  logic [3:0]      shad_dp_q, shad_dp_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [3:0]      dsel_q, dsel_d;
  logic            fd_q, fd_d;
  logic            err_q, err_d;
  logic            boundary, swap, take;
  logic [3:0]      nib_d;
  logic            en_d, lz_d;

  function automatic logic [6:0] enc7(input logic [3:0] n);
    case (n)
      4'd0:    enc7 = 7'h3F;
      4'd1:    enc7 = 7'h06;
      4'd2:    enc7 = 7'h5B;
      4'd3:    enc7 = 7'h4F;
      4'd4:    enc7 = 7'h66;
      4'd5:    enc7 = 7'h6D;
      4'd6:    enc7 = 7'h7D;
      4'd7:    enc7 = 7'h07;
      4'd8:    enc7 = 7'h7F;
      4'd9:    enc7 = 7'h6F;
      default: enc7 = 7'h40;
    endcase
  endfunction

  assign in_if.in_ready = ~pend_full_q;
  assign seg_out_o      = seg_q;
  assign dp_out_o       = dp_q;
  assign dig_sel_o      = dsel_q;
  assign frame_done_o   = fd_q;
  assign err_bcd_o      = err_q;

  // Scan sequencing and pending/shadow buffer next-state.
  always_comb begin
    phase_d = phase_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q + 1'b1;
    pwm_d   = pwm_q + 4'd1;
    if (phase_q == PH_BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        phase_d = PH_ON;
        cnt_d   = '0;
        pwm_d   = 4'd0;
      end
    end else begin
      if (cnt_q == ON_LAST) begin
        phase_d = PH_BLANK;
        cnt_d   = '0;
        dig_d   = dig_q + 2'd1;
      end
    end

    boundary    = (phase_q == PH_ON) && (dig_q == 2'd3) && (cnt_q == ON_LAST);
    swap        = boundary && pend_full_q;
    take        = in_if.in_valid && !pend_full_q;
    pend_full_d = take ? 1'b1 : (swap ? 1'b0 : pend_full_q);
    pend_bcd_d  = take ? in_if.in_bcd : pend_bcd_q;
    pend_dp_d   = take ? in_if.in_dp  : pend_dp_q;
    shad_bcd_d  = swap ? pend_bcd_q : shad_bcd_q;
    shad_dp_d   = swap ? pend_dp_q  : shad_dp_q;
  end

  // Output values for the upcoming cycle, so registered outputs line up with the scan state.
  always_comb begin
    nib_d = shad_bcd_d[{dig_d, 2'b00} +: 4];
    en_d  = (phase_d == PH_ON) && ((brightness_i == 4'd15) || (pwm_d <= brightness_i));
    case (dig_d)
      2'd3:    lz_d = blank_lz_i && (shad_bcd_d[15:12] == 4'd0);
      2'd2:    lz_d = blank_lz_i && (shad_bcd_d[15:8]  == 8'd0);
      2'd1:    lz_d = blank_lz_i && (shad_bcd_d[15:4]  == 12'd0);
      default: lz_d = 1'b0;
    endcase
    seg_d  = (en_d && !lz_d) ? enc7(nib_d) : 7'd0;
    dp_d   = en_d ? shad_dp_d[dig_d] : 1'b0;
    dsel_d = en_d ? (4'b0001 << dig_d) : 4'b0000;
    fd_d   = (phase_d == PH_ON) && (dig_d == 2'd3) && (cnt_d == ON_LAST);
    err_d  = err_q || (en_d && (nib_d > 4'd9));
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= PH_BLANK;
      dig_q       <= 2'd0;
      cnt_q       <= '0;
      pwm_q       <= 4'd0;
      pend_full_q <= 1'b0;
      pend_bcd_q  <= 16'd0;
      pend_dp_q   <= 4'd0;
      shad_bcd_q  <= 16'd0;
      shad_dp_q   <= 4'd0;
      seg_q       <= 7'd0;
      dp_q        <= 1'b0;
      dsel_q      <= 4'd0;
      fd_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      dig_q       <= dig_d;
      cnt_q       <= cnt_d;
      pwm_q       <= pwm_d;
      pend_full_q <= pend_full_d;
      pend_bcd_q  <= pend_bcd_d;
      pend_dp_q   <= pend_dp_d;
      shad_bcd_q  <= shad_bcd_d;
      shad_dp_q   <= shad_dp_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      dsel_q      <= dsel_d;
      fd_q        <= fd_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with SCAN_DIV=8, BLANK_CYCLES=2 (40-cycle frame).
// Frame offsets after a frame_done cycle: k=1..40, digit (k-1)/10, blank for the first 2 of each 10.
module tb_seg7_scan_mux;
  logic       clk = 1'b0;
  logic       reset;
  logic       blank_lz;
  logic [3:0] brightness;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] dig_sel;
  logic       frame_done;
  logic       err_bcd;
  int         checks = 0;
  int         failures = 0;

  seg7_scan_mux_if bus ();

  seg7_scan_mux #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_if        (bus.slave),
    .blank_lz_i   (blank_lz),
    .brightness_i (brightness),
    .seg_out_o    (seg_out),
    .dp_out_o     (dp_out),
    .dig_sel_o    (dig_sel),
    .frame_done_o (frame_done),
    .err_bcd_o    (err_bcd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_fd(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic xfer(input logic [15:0] bcd, input logic [3:0] dp);
    chk("xfer_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_bcd   = bcd;
    bus.in_dp    = dp;
    tick();
    bus.in_valid = 1'b0;
    chk("xfer_taken", {31'd0, bus.in_ready}, 32'd0);
  endtask

  // segs = {digit3,digit2,digit1,digit0} hand-encoded 7-bit patterns.
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dpv,
                             input logic [3:0] b, input int k0, input int err_dig, input logic err0);
    int         d;
    int         p;
    logic       en;
    logic       err_e;
    logic [3:0] dsel;
    logic [6:0] sg;
    logic       dpb;
    logic [13:0] ex;
    logic [13:0] ob;
    err_e = err0;
    for (int k = k0 + 1; k <= 40; k++) begin
      tick();
      d  = (k - 1) / 10;
      p  = (k - 1) % 10;
      en = (p >= 2) && ((b == 4'd15) || ((p - 2) <= int'(b)));
      if (en && (d == err_dig)) err_e = 1'b1;
      dsel = en ? (4'b0001 << d) : 4'b0000;
      sg   = en ? segs[d*7 +: 7] : 7'd0;
      dpb  = en ? dpv[d] : 1'b0;
      ex   = {(k == 40), dsel, sg, dpb, err_e};
      ob   = {frame_done, dig_sel, seg_out, dp_out, err_bcd};
      chk(tag, {18'd0, ob}, {18'd0, ex});
    end
  endtask

  initial begin
    reset        = 1'b1;
    blank_lz     = 1'b0;
    brightness   = 4'd15;
    bus.in_valid = 1'b0;
    bus.in_bcd   = 16'd0;
    bus.in_dp    = 4'd0;
    tick(); tick(); tick();
    chk("rst_outs", {18'd0, frame_done, dig_sel, seg_out, dp_out, err_bcd}, 32'd0);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);

    // First scan after release: blank, blank, then digit0 on (shadow 0 -> 3F).
    reset = 1'b0;
    tick(); tick();
    chk("start_on0", {21'd0, dig_sel, seg_out}, {21'd0, 4'b0001, 7'h3F});
    tick(); tick();

    // Reset held three cycles mid-ON.
    reset = 1'b1;
    tick();
    chk("midrst_outs", {20'd0, dig_sel, seg_out, err_bcd}, 32'd0);
    chk("midrst_ready", {31'd0, bus.in_ready}, 32'd1);
    tick(); tick();
    reset = 1'b0;
    chk("rel_c0", {28'd0, dig_sel}, 32'd0);
    tick();
    chk("rel_c1", {28'd0, dig_sel}, 32'd0);
    tick();
    chk("rel_c2", {28'd0, dig_sel}, 32'd1);

    // Word 1234 with dp on digit 2, full brightness.
    xfer(16'h1234, 4'b0100);
    wait_fd("fd_1234");
    chk("rdy_at_fd", {31'd0, bus.in_ready}, 32'd0);
    check_frame("f_1234", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, 4'd15, 0, -1, 1'b0);
    chk("rdy_after_fd", {31'd0, bus.in_ready}, 32'd1);

    // Transfer on the boundary cycle itself: old word stays one more frame.
    blank_lz = 1'b1;
    xfer(16'h0070, 4'b0000);
    check_frame("f_keep1234", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100, 4'd15, 1, -1, 1'b0);
    check_frame("f_lz0070", {7'h00, 7'h00, 7'h07, 7'h3F}, 4'b0000, 4'd15, 0, -1, 1'b0);
    tick(); tick(); tick();
    xfer(16'h0000, 4'b0000);
    wait_fd("fd_0000");
    check_frame("f_lz0000", {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, 4'd15, 0, -1, 1'b0);
    blank_lz = 1'b0;

    // A then B with B held valid through backpressure.
    tick(); tick(); tick(); tick(); tick();
    begin
      logic bad;
      logic seen;
      bus.in_valid = 1'b1;
      bus.in_bcd   = 16'h5678;
      bus.in_dp    = 4'b0000;
      tick();
      bus.in_bcd   = 16'h9012;
      bus.in_dp    = 4'b0001;
      bad  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (frame_done === 1'b1) begin
          seen = 1'b1;
          break;
        end
        if (bus.in_ready !== 1'b0) bad = 1'b1;
        tick();
      end
      chk("ab_hold_low", {31'd0, bad}, 32'd0);
      chk("ab_fd_seen", {31'd0, seen}, 32'd1);
      chk("ab_rdy_fd", {31'd0, bus.in_ready}, 32'd0);
      tick();
      chk("b_rdy", {31'd0, bus.in_ready}, 32'd1);
      tick();
      chk("b_taken", {31'd0, bus.in_ready}, 32'd0);
      bus.in_valid = 1'b0;
    end
    check_frame("f_A", {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b0000, 4'd15, 2, -1, 1'b0);
    check_frame("f_B", {7'h6F, 7'h3F, 7'h06, 7'h5B}, 4'b0001, 4'd15, 0, -1, 1'b0);

    // PWM at brightness 3.
    tick(); tick(); tick();
    xfer(16'h8888, 4'b1111);
    brightness = 4'd3;
    wait_fd("fd_8888");
    check_frame("f_pwm3", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111, 4'd3, 0, -1, 1'b0);
    brightness = 4'd15;

    // Invalid nibble in digit 2, then a clean word: error stays sticky.
    tick(); tick(); tick();
    xfer(16'h0C00, 4'b0000);
    wait_fd("fd_0C00");
    chk("err_before", {31'd0, err_bcd}, 32'd0);
    check_frame("f_err", {7'h3F, 7'h40, 7'h3F, 7'h3F}, 4'b0000, 4'd15, 0, 2, 1'b0);
    tick(); tick(); tick();
    xfer(16'h4321, 4'b0000);
    wait_fd("fd_4321");
    check_frame("f_sticky", {7'h66, 7'h4F, 7'h5B, 7'h06}, 4'b0000, 4'd15, 0, -1, 1'b1);
    reset = 1'b1;
    tick();
    chk("err_cleared", {31'd0, err_bcd}, 32'd0);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
